// File: rtl/hexdisplay_scan.sv
//----------------------------------------------------------------------------
// hexdisplay_scan : time-multiplexed N-digit hex 7-segment driver with
// shadow/active data, PWM brightness and frame strobe.
// Optional macro HEXDISPLAY_ZERO_BLANK_EN enables leading-zero blanking.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module hexdisplay_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 100000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  input  logic [3:0]              brightness,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [7:0]              catode,
  output logic                    frame_tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = CW + 5;
  localparam logic [CW-1:0]         CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0]         DIV_P    = PW'(SCAN_DIV);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [7:0]            CA_OFF   = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] shadow_data, act_data;
  logic [NUM_DIGITS-1:0]   shadow_dp, act_dp;
  logic [NUM_DIGITS-1:0]   shadow_en, act_en;

  logic [NUM_DIGITS-1:0]   blank;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_en;
  logic                    cur_blank;
  logic                    lit;
  logic [NUM_DIGITS-1:0]   anode_nxt;
  logic [PW-1:0]           cnt_scaled;
  logic [PW-1:0]           duty_limit;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

`ifdef HEXDISPLAY_ZERO_BLANK_EN
  logic upper_zero;

  // Walk from the top digit down; digit 0 is never blanked.
  always_comb begin
    blank      = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero && (act_data[4*i +: 4] == 4'h0);
      blank[i]   = upper_zero && !act_dp[i];
    end
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_en    = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib   = act_data[4*i +: 4];
        cur_dp    = act_dp[i];
        cur_en    = act_en[i];
        cur_blank = blank[i];
      end
    end
  end

  // Duty compare is widened so (brightness+1)*SCAN_DIV cannot overflow.
  assign cnt_scaled = PW'({cnt, 4'b0000});
  assign duty_limit = (PW'(brightness) + PW'(1)) * DIV_P;
  assign lit        = cur_en && !cur_blank && (cnt_scaled < duty_limit);

  always_comb begin
    anode_nxt = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) anode_nxt[i] = lit;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      idx         <= '0;
      shadow_data <= '0;
      shadow_dp   <= '0;
      shadow_en   <= '0;
      act_data    <= '0;
      act_dp      <= '0;
      act_en      <= '0;
      frame_tick  <= 1'b0;
      anode       <= AN_OFF;
      catode      <= CA_OFF;
    end else begin
      frame_tick <= 1'b0;
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        if (idx == IDX_LAST) begin
          // Frame start: active takes the pre-edge shadow, even if load is high.
          idx        <= '0;
          act_data   <= shadow_data;
          act_dp     <= shadow_dp;
          act_en     <= shadow_en;
          frame_tick <= 1'b1;
        end else begin
          idx <= idx + IW'(1);
        end
      end else begin
        cnt <= cnt + CW'(1);
      end

      if (load) begin
        shadow_data <= data;
        shadow_dp   <= dp;
        shadow_en   <= digit_en;
      end

      anode  <= anode_nxt ^ AN_OFF;
      catode <= (lit ? {cur_dp, hex7(cur_nib)} : 8'h00) ^ CA_OFF;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hexdisplay_scan.sv
//----------------------------------------------------------------------------
// tb_hexdisplay_scan : scoreboard bench for hexdisplay_scan (4 digits,
// SCAN_DIV=16, active-low); honours HEXDISPLAY_ZERO_BLANK_EN when defined.
//----------------------------------------------------------------------------
`default_nettype none

module tb_hexdisplay_scan;

  localparam int ND = 4;
  localparam int SD = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data;
  logic [3:0]  dp;
  logic [3:0]  digit_en;
  logic        load;
  logic [3:0]  brightness;
  logic [3:0]  anode;
  logic [7:0]  catode;
  logic        frame_tick;

  int tests = 0;
  int fails = 0;

  hexdisplay_scan #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .ACTIVE_LOW(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .data       (data),
    .dp         (dp),
    .digit_en   (digit_en),
    .load       (load),
    .brightness (brightness),
    .anode      (anode),
    .catode     (catode),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] ca;
    logic       tk;
  } exp_t;

  exp_t sbq[$];

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: position in the scan is derived from elapsed cycles.
  int unsigned t;
  logic [15:0] sh_d, ac_d;
  logic [3:0]  sh_dp, ac_dp, sh_en, ac_en;

  always @(posedge clk) begin : model
    exp_t       e;
    int         c, i;
    logic       on;
    logic [3:0] nib;
    logic [7:0] seg;
    if (reset) begin
      e = '{an: 4'hF, ca: 8'hFF, tk: 1'b0};
      t = 0;
      sh_d = '0; sh_dp = '0; sh_en = '0;
      ac_d = '0; ac_dp = '0; ac_en = '0;
    end else begin
      c   = int'(t % SD);
      i   = int'((t / SD) % ND);
      nib = 4'((ac_d >> (4 * i)) & 16'hF);
      on  = ac_en[i] && ((c * 16) < ((int'(brightness) + 1) * SD));
`ifdef HEXDISPLAY_ZERO_BLANK_EN
      if (i > 0 && (ac_d >> (4 * i)) == 16'h0 && !ac_dp[i]) on = 1'b0;
`endif
      seg  = {ac_dp[i], hex_tab[nib]};
      e.an = on ? ~(4'b0001 << i) : 4'hF;
      e.ca = on ? ~seg : 8'hFF;
      e.tk = (c == SD - 1) && (i == ND - 1);
      if (e.tk) begin
        ac_d = sh_d; ac_dp = sh_dp; ac_en = sh_en;
      end
      if (load) begin
        sh_d = data; sh_dp = dp; sh_en = digit_en;
      end
      t++;
    end
    sbq.push_back(e);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      tests++;
      if (anode !== e.an || catode !== e.ca || frame_tick !== e.tk) begin
        fails++;
        $display("FAIL scoreboard @%0t: got anode=%b catode=%b tick=%b, expected anode=%b catode=%b tick=%b",
                 $time, anode, catode, frame_tick, e.an, e.ca, e.tk);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] en);
    @(negedge clk);
    data = d; dp = p; digit_en = en; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < 300);
    if (frame_tick !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL wait_tick: no frame_tick within %0d cycles", n);
    end
  endtask

  task automatic count_lit(output int lit_cnt, output int d2_on, output int dp_on);
    lit_cnt = 0; d2_on = 0; dp_on = 0;
    repeat (64) begin
      @(negedge clk);
      if (anode != 4'hF) lit_cnt++;
      if (anode[2] == 1'b0) d2_on++;
      if (anode != 4'hF && catode[7] == 1'b0) dp_on++;
    end
  endtask

  initial begin : stim
    int n, lc, d2, dpc, k;
    reset = 1'b1; data = '0; dp = '0; digit_en = '0; load = 1'b0; brightness = 4'd15;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    do_load(16'h12AF, 4'h0, 4'hF);

    wait_tick(n);
    @(negedge clk);
    check("digit0_anode", int'(anode), 'hE);
    check("digit0_catode", int'(catode), 'h8E);
    repeat (16) @(negedge clk);
    check("digit1_anode", int'(anode), 'hD);
    check("digit1_catode", int'(catode), 'h88);
    wait_tick(n);
    wait_tick(n);
    check("tick_period", n, 64);

    brightness = 4'd3;
    wait_tick(n);
    count_lit(lc, d2, dpc);
    check("lit_b3", lc, 16);
    brightness = 4'd0;
    wait_tick(n);
    count_lit(lc, d2, dpc);
    check("lit_b0", lc, 4);
    brightness = 4'd15;

    // Load on the same edge that produces frame_tick.
    wait_tick(n);
    repeat (63) @(negedge clk);
    data = 16'h5555; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("tick_at_load", int'(frame_tick), 1);
    @(negedge clk);
    check("old_value_kept", int'(catode), 'h8E);
    wait_tick(n);
    @(negedge clk);
    check("new_value_shown", int'(catode), 'h92);

    do_load(16'h12AF, 4'b0100, 4'b1011);
    wait_tick(n);
    wait_tick(n);
    count_lit(lc, d2, dpc);
    check("d2_never_lit", d2, 0);
    check("dp_off_others", dpc, 0);
    check("lit_masked", lc, 48);

    do_load(16'h12AF, 4'h0, 4'hF);
    wait_tick(n);
    wait_tick(n);
    k = 0;
    while (anode !== 4'b1011 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("found_digit2", int'(anode), 'hB);
    reset = 1'b1;
    @(negedge clk);
    check("reset_anode", int'(anode), 'hF);
    check("reset_catode", int'(catode), 'hFF);
    check("reset_tick", int'(frame_tick), 0);
    reset = 1'b0;
    wait_tick(n);
    check("restart_period", n, 64);

    do_load(16'h0030, 4'h0, 4'hF);
    wait_tick(n);
    wait_tick(n);
    count_lit(lc, d2, dpc);
`ifdef HEXDISPLAY_ZERO_BLANK_EN
    check("blank_0030", lc, 32);
`else
    check("blank_0030", lc, 64);
`endif
    do_load(16'h0000, 4'h0, 4'hF);
    wait_tick(n);
    wait_tick(n);
    count_lit(lc, d2, dpc);
`ifdef HEXDISPLAY_ZERO_BLANK_EN
    check("blank_0000", lc, 16);
`else
    check("blank_0000", lc, 64);
`endif

    // Randomised traffic, checked cycle by cycle by the scoreboard.
    repeat (1200) begin
      @(negedge clk);
      load = ($urandom_range(0, 5) == 0);
      data = 16'($urandom);
      if ($urandom_range(0, 15) == 0) dp = 4'($urandom);
      if ($urandom_range(0, 15) == 0) digit_en = 4'($urandom);
      if ($urandom_range(0, 31) == 0) brightness = 4'($urandom);
      reset = ($urandom_range(0, 399) == 0);
    end
    load = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
